// File: rtl/hazard_stall.sv
// ---------------------------------------------------------------------------
// hazard_stall
//
// Interlock and flush controller for the LC-3b 5-stage pipeline. Covers the
// hazards forwarding cannot: load-use dependences, instruction/data memory
// wait states and taken-branch squashes. All control outputs are Mealy
// (combinational from state + inputs). A two-state FSM remembers that an
// outstanding instruction fetch belongs to a squashed path.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles / flush_count are saturating 16-bit counters
//   undefined -> both ports are tied to zero and no counters exist
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   IF_ID_opcode/sr1/sr2     decode-stage instruction fields
//   IF_ID_bit5, IF_ID_bit11  immediate select / JSR mode bits
//   ID_EX_mem_read           EX-stage instruction is a load
//   ID_EX_reg_write          EX-stage instruction writes the register file
//   ID_EX_dest               EX-stage destination register
//   imem_req, imem_resp      fetch outstanding / fetch data valid
//   dmem_req, dmem_resp      data access outstanding / data valid
//   branch_taken             MEM stage resolved a taken control transfer
//   *_load                   pipeline register load enables
//   IF_ID_bubble, ID_EX_bubble             load a NOP instead of upstream data
//   IF_ID_flush, ID_EX_flush, EX_MEM_flush squash the register to a NOP
//   stall_cycles, flush_count              performance counters
// ---------------------------------------------------------------------------
module hazard_stall (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  IF_ID_opcode,
    input  logic [2:0]  IF_ID_sr1,
    input  logic [2:0]  IF_ID_sr2,
    input  logic        IF_ID_bit5,
    input  logic        IF_ID_bit11,
    input  logic        ID_EX_mem_read,
    input  logic        ID_EX_reg_write,
    input  logic [2:0]  ID_EX_dest,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        branch_taken,
    output logic        pc_load,
    output logic        IF_ID_load,
    output logic        ID_EX_load,
    output logic        EX_MEM_load,
    output logic        MEM_WB_load,
    output logic        IF_ID_bubble,
    output logic        ID_EX_bubble,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_SHF = 4'b1101;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JSR = 4'b0100;

    typedef enum logic {
        RUN,
        DISCARD
    } state_e;

    state_e state_q, state_d;

    logic sr1_used;
    logic sr2_used;
    logic load_use;
    logic dwait;
    logic iwait;

    // Raw control decisions before reset gating.
    logic pc_load_c, if_id_load_c, id_ex_load_c, ex_mem_load_c, mem_wb_load_c;
    logic if_id_bubble_c, id_ex_bubble_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;

    // ------------------------------------------------------------------
    // Source-register usage of the instruction in decode. Store data
    // (the SR field of STR/STB/STI) is forwarded, so it never interlocks.
    // ------------------------------------------------------------------
    always_comb begin
        sr1_used = 1'b0;
        sr2_used = 1'b0;
        case (IF_ID_opcode)
            OP_ADD, OP_AND: begin
                sr1_used = 1'b1;
                sr2_used = ~IF_ID_bit5;
            end
            OP_NOT, OP_LDR, OP_LDB, OP_LDI,
            OP_STR, OP_STB, OP_STI, OP_SHF, OP_JMP: sr1_used = 1'b1;
            OP_JSR:  sr1_used = ~IF_ID_bit11;   // JSRR reads its base register
            default: begin
                sr1_used = 1'b0;
                sr2_used = 1'b0;
            end
        endcase
    end

    assign load_use = ID_EX_mem_read & ID_EX_reg_write &
                      ((sr1_used & (ID_EX_dest == IF_ID_sr1)) |
                       (sr2_used & (ID_EX_dest == IF_ID_sr2)));

    assign dwait = dmem_req & ~dmem_resp;
    assign iwait = imem_req & ~imem_resp;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                // A branch squashing a still-pending fetch orphans that fetch.
                if (!dwait && branch_taken && iwait) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // The orphaned word is dropped whenever it arrives, even
                // during a data freeze (IF/ID is not loaded then anyway).
                if (imem_resp) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_load_c      = 1'b1;
        if_id_load_c   = 1'b1;
        id_ex_load_c   = 1'b1;
        ex_mem_load_c  = 1'b1;
        mem_wb_load_c  = 1'b1;
        if_id_bubble_c = 1'b0;
        id_ex_bubble_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        case (state_q)
            RUN: begin
                if (dwait) begin
                    pc_load_c     = 1'b0;
                    if_id_load_c  = 1'b0;
                    id_ex_load_c  = 1'b0;
                    ex_mem_load_c = 1'b0;
                    mem_wb_load_c = 1'b0;
                end else if (branch_taken) begin
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_load_c      = 1'b0;
                    if_id_load_c   = 1'b0;
                    id_ex_bubble_c = 1'b1;
                end else if (iwait) begin
                    pc_load_c      = 1'b0;
                    if_id_bubble_c = 1'b1;
                end
            end
            DISCARD: begin
                if (dwait) begin
                    pc_load_c     = 1'b0;
                    if_id_load_c  = 1'b0;
                    id_ex_load_c  = 1'b0;
                    ex_mem_load_c = 1'b0;
                    mem_wb_load_c = 1'b0;
                end else begin
                    pc_load_c      = 1'b0;
                    if_id_bubble_c = 1'b1;
                end
            end
            default: begin
                pc_load_c = 1'b1;
            end
        endcase
    end

    // Every control output is held inactive while reset is asserted.
    assign pc_load      = rst_n & pc_load_c;
    assign IF_ID_load   = rst_n & if_id_load_c;
    assign ID_EX_load   = rst_n & id_ex_load_c;
    assign EX_MEM_load  = rst_n & ex_mem_load_c;
    assign MEM_WB_load  = rst_n & mem_wb_load_c;
    assign IF_ID_bubble = rst_n & if_id_bubble_c;
    assign ID_EX_bubble = rst_n & id_ex_bubble_c;
    assign IF_ID_flush  = rst_n & if_id_flush_c;
    assign ID_EX_flush  = rst_n & id_ex_flush_c;
    assign EX_MEM_flush = rst_n & ex_mem_flush_c;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_load && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (EX_MEM_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
